ula_arbiter: RTL and testbench
==============================

Name: ula_arbiter

Overview:
- Shares one combinational 8-bit ALU (AND/OR/ADD/SUB with signed-overflow flag) between two requesters.
- Each requester uses a valid/ready handshake. Grants are round-robin.
- The ALU result, overflow flag and requester ID are registered into a single-entry output buffer, drained by a valid/ready consumer.
- Sits between the switch/stimulus front-ends and the LED/display back-end of the lab top level.

Parameters:
- N_BITS, 8, operand/result width (signed two's complement).
- CNT_BITS, 8, width of the saturating overflow counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  N_BITS  operand A (signed).
- req0_b  input  N_BITS  operand B (signed).
- req0_f  input  2  opcode: 00 AND, 01 OR, 10 ADD, 11 SUB.
- req1_valid, req1_ready, req1_a, req1_b, req1_f: same as requester 0, for requester 1.
- rsp_valid  output  1  output buffer holds a result.
- rsp_ready  input  1  consumer takes the result.
- rsp_id  output  1  requester that issued the result.
- rsp_result  output  N_BITS  ALU result.
- rsp_flag_o  output  1  signed overflow of that operation.
- ovf_count  output  CNT_BITS  number of overflowing operations since reset, saturating.

Behaviour:
- Single clock. All state updates on the rising edge of clk.
- Reset is synchronous and active-high. While reset is high at an edge:
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flag_o=0, ovf_count=0.
  - last_grant=1, so requester 0 wins the first tie.
  - The FSM goes to EMPTY.
- Reset mid-operation drops any buffered result. No ready is asserted in the reset cycle.
- FSM has two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = (state==EMPTY) || rsp_ready. This gives a pass-through drain: a new result can load in the same cycle the old one is taken.
- Grant (combinational, evaluated only when can_accept):
  - Only one valid: that requester is granted.
  - Both valid: grant the requester opposite to last_grant.
  - reqN_ready = can_accept && grantN. At most one ready is high per cycle.
- Accept cycle: on the edge where reqX_valid && reqX_ready:
  - Buffer loads result, flag and id=X.
  - State becomes FULL; last_grant becomes X.
  - Latency: accept at edge t, rsp_valid visible after edge t. One result per cycle sustained.
- Drain without refill: rsp_valid && rsp_ready with no grant sends the FSM to EMPTY. Outputs keep their last values; only rsp_valid falls.
- FULL && !rsp_ready: the buffer holds its contents stable and both readies are 0.
- ALU arithmetic: N_BITS wrap-around.
  - ADD: R = A+B; overflow = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - SUB: R = A-B; overflow = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
  - AND/OR: flag=0.
- ovf_count increments on each accepted operation whose flag=1. It holds at 2^CNT_BITS-1.
- Requester inputs are sampled only on the accept edge. They may change freely otherwise.

Optional Feature:
- Macro: ULA_SAT_EN.
- Defined: an overflowing ADD/SUB result is clamped.
  - A[msb]=0 gives 0x7F (max positive).
  - A[msb]=1 gives 0x80 (min negative).
  - rsp_flag_o still reads 1 and ovf_count still counts.
- Undefined: the result wraps modulo 2^N_BITS.

Decomposition:
- Package ula_pkg holds:
  - enum alu_op_t {OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_SUB=2'b11}.
  - enum rsp_state_t {EMPTY, FULL}.
  - Default constant N_BITS=8.
- Sub-module alu_core: purely combinational (A, B, F → result, flag_o), including the ULA_SAT_EN clamp.
- ula_arbiter: arbitration, FSM, output buffer and counter.

Test Plan:
- Reset, then req0 only: A=0x05, B=0x03, F=ADD → one cycle later rsp_valid=1, rsp_result=0x08, rsp_flag_o=0, rsp_id=0.
- Both valid every cycle, rsp_ready=1:
  - req0 = 0x70 ADD 0x10.
  - req1 = 0x0F AND 0x3C.
  - Expect rsp_id alternating 0,1,0,1.
  - req0 results 0x80 with flag=1 (0x7F with ULA_SAT_EN).
  - req1 results 0x0C with flag=0.
  - ovf_count increments on every other cycle.
- SUB overflow: A=0x80, B=0x01 → result 0x7F, flag=1 (0x80 with ULA_SAT_EN). SUB 0x05−0x07 → 0xFE, flag=0.
- Backpressure: hold rsp_ready=0 for 4 cycles while both requesters are valid → both readies stay 0 and the buffer stays stable. Release → the next grant goes to the requester opposite the buffered id.
- ovf_count saturation: 260 overflowing ADDs (0x7F+0x01) → ovf_count=255 and stays there.
- Reset asserted while FULL and stalled → next cycle rsp_valid=0, ovf_count=0. The first tie after reset is granted to req0.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared types and defaults for the ULA arbiter slice.
// Optional build macro ULA_SAT_EN (used in alu_core) clamps overflowing ADD/SUB results.
package ula_pkg;

    localparam int N_BITS   = 8;
    localparam int CNT_BITS = 8;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational signed ALU: AND / OR / ADD / SUB with signed-overflow flag.
// Build macro ULA_SAT_EN: when defined, an overflowing ADD/SUB is clamped to
// max positive (A non-negative) or min negative (A negative); otherwise it wraps.
module alu_core
    import ula_pkg::*;
#(
    parameter int N_BITS = ula_pkg::N_BITS
) (
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    input  logic [1:0]        f,
    output logic [N_BITS-1:0] result,
    output logic              flag_o
);

    localparam int MSB = N_BITS - 1;

    alu_op_t           op;
    logic [N_BITS-1:0] sum;
    logic [N_BITS-1:0] diff;

    assign op   = alu_op_t'(f);
    assign sum  = a + b;
    assign diff = a - b;

    // Select the operation result and detect signed overflow.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        result = '0;
        flag_o = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD: begin
                result = sum;
                flag_o = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                result = diff;
                flag_o = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            default: ;
        endcase
`ifdef ULA_SAT_EN
        if (flag_o) begin
            result = a[MSB] ? {1'b1, {(N_BITS-1){1'b0}}} : {1'b0, {(N_BITS-1){1'b1}}};
        end
`endif
    end

endmodule

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one alu_core between two valid/ready requesters.
// Results land in a single-entry output buffer with pass-through drain, and a
// saturating counter tracks overflowing operations. Honours ULA_SAT_EN via alu_core.
module ula_arbiter
    import ula_pkg::*;
#(
    parameter int N_BITS   = ula_pkg::N_BITS,
    parameter int CNT_BITS = ula_pkg::CNT_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [N_BITS-1:0]   req0_a,
    input  logic [N_BITS-1:0]   req0_b,
    input  logic [1:0]          req0_f,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [N_BITS-1:0]   req1_a,
    input  logic [N_BITS-1:0]   req1_b,
    input  logic [1:0]          req1_f,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [N_BITS-1:0]   rsp_result,
    output logic                rsp_flag_o,
    output logic [CNT_BITS-1:0] ovf_count
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

    rsp_state_t        state_q;
    rsp_state_t        state_d;
    logic              last_grant;
    logic              can_accept;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic [N_BITS-1:0] alu_a;
    logic [N_BITS-1:0] alu_b;
    logic [1:0]        alu_f;
    logic [N_BITS-1:0] alu_result;
    logic              alu_flag;

    // Round-robin grant; a tie goes to the requester that did not win last time.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // Readies are suppressed while reset is asserted so nothing is accepted then.
    assign can_accept = (state_q == EMPTY) || rsp_ready;
    assign req0_ready = !reset && can_accept && grant0;
    assign req1_ready = !reset && can_accept && grant1;
    assign accept     = req0_ready || req1_ready;

    // Steer the granted requester's operands into the shared ALU.
    assign alu_a = grant1 ? req1_a : req0_a;
    assign alu_b = grant1 ? req1_b : req0_b;
    assign alu_f = grant1 ? req1_f : req0_f;

    alu_core #(.N_BITS(N_BITS)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .f      (alu_f),
        .result (alu_result),
        .flag_o (alu_flag)
    );

    // Output buffer state register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all sequential state so every flop samples pre-edge values.
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // Next state: a load always leaves the buffer FULL; a drain without refill empties it.
    always_comb begin
        state_d = state_q;
        if (accept)                             state_d = FULL;
        else if (state_q == FULL && rsp_ready)  state_d = EMPTY;
    end

    assign rsp_valid = (state_q == FULL);

    // Buffer payload and round-robin history; loaded only on an accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flag_o <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            rsp_id     <= grant1;
            rsp_result <= alu_result;
            rsp_flag_o <= alu_flag;
            last_grant <= grant1;
        end
    end

    // Saturating count of accepted operations that overflowed.
    always_ff @(posedge clk) begin
        if (reset)                                       ovf_count <= '0;
        else if (accept && alu_flag && ovf_count != CNT_MAX) ovf_count <= ovf_count + 1'b1;
    end

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed self-checking bench for ula_arbiter; expected values are hand-computed.
// Build with ULA_SAT_EN defined to exercise the clamped-result variant.
module tb_ula_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_f, req1_f;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_flag_o;
    logic [7:0] rsp_result;
    logic [7:0] ovf_count;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] F_AND = 2'b00, F_OR = 2'b01, F_ADD = 2'b10, F_SUB = 2'b11;

`ifdef ULA_SAT_EN
    localparam logic [7:0] ADD_70_10 = 8'h7F;
    localparam logic [7:0] SUB_80_01 = 8'h80;
    localparam logic [7:0] ADD_7F_01 = 8'h7F;
`else
    localparam logic [7:0] ADD_70_10 = 8'h80;
    localparam logic [7:0] SUB_80_01 = 8'h7F;
    localparam logic [7:0] ADD_7F_01 = 8'h80;
`endif

    always #5 clk = ~clk;

    ula_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_f     (req0_f),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_f     (req1_f),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flag_o (rsp_flag_o),
        .ovf_count  (ovf_count)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic id,
                             input logic [7:0] res, input logic flg, input logic [7:0] cnt);
        check({tag, ".valid"},  rsp_valid,  v);
        check({tag, ".id"},     rsp_id,     id);
        check({tag, ".result"}, rsp_result, res);
        check({tag, ".flag"},   rsp_flag_o, flg);
        check({tag, ".ovf"},    ovf_count,  cnt);
    endtask

    initial begin
        reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h03; req0_f = F_ADD;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_f = F_AND;
        tick(); tick();
        check_rsp("reset", 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
        check("reset.rdy0", req0_ready, 1'b0);

        // Single request from req0: 5 + 3.
        reset = 1'b0; rsp_ready = 1'b1;
        #1;
        check("single.rdy0", req0_ready, 1'b1);
        tick();
        check_rsp("single", 1'b1, 1'b0, 8'h08, 1'b0, 8'd0);

        // Drain with no refill: only rsp_valid falls.
        req0_valid = 1'b0;
        tick();
        check_rsp("drain", 1'b0, 1'b0, 8'h08, 1'b0, 8'd0);

        // SUB overflow and plain SUB via req1.
        req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h01; req1_f = F_SUB;
        tick();
        check_rsp("sub_ovf", 1'b1, 1'b1, SUB_80_01, 1'b1, 8'd1);
        req1_a = 8'h05; req1_b = 8'h07;
        tick();
        check_rsp("sub", 1'b1, 1'b1, 8'hFE, 1'b0, 8'd1);

        // Both valid every cycle: alternating grants starting with req0.
        req0_valid = 1'b1; req0_a = 8'h70; req0_b = 8'h10; req0_f = F_ADD;
        req1_a = 8'h0F; req1_b = 8'h3C; req1_f = F_AND;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i % 2 == 0) check_rsp("alt0", 1'b1, 1'b0, ADD_70_10, 1'b1, 8'(2 + i / 2));
            else            check_rsp("alt1", 1'b1, 1'b1, 8'h0C, 1'b0, 8'(2 + i / 2));
        end

        // Backpressure: buffer holds id1/0x0C, both readies low.
        rsp_ready = 1'b0;
        req0_a = 8'h01; req0_b = 8'h02; req0_f = F_ADD;
        req1_a = 8'h10; req1_b = 8'h01; req1_f = F_OR;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp.rdy0", req0_ready, 1'b0);
            check("bp.rdy1", req1_ready, 1'b0);
            tick();
            check_rsp("bp", 1'b1, 1'b1, 8'h0C, 1'b0, 8'd3);
        end
        rsp_ready = 1'b1;
        #1;
        check("rel.rdy0", req0_ready, 1'b1);
        check("rel.rdy1", req1_ready, 1'b0);
        tick();
        check_rsp("rel", 1'b1, 1'b0, 8'h03, 1'b0, 8'd3);

        // Counter saturation with 260 overflowing ADDs from req0.
        req1_valid = 1'b0;
        req0_a = 8'h7F; req0_b = 8'h01; req0_f = F_ADD;
        for (int i = 0; i < 260; i++) begin
            tick();
            if (i == 100) check("sat.mid", ovf_count, 8'd104);
        end
        check_rsp("sat", 1'b1, 1'b0, ADD_7F_01, 1'b1, 8'd255);
        tick();
        check("sat.hold", ovf_count, 8'd255);

        // Reset while FULL and stalled.
        rsp_ready = 1'b0;
        req0_a = 8'h01; req0_b = 8'h01;
        tick();
        check("stall.valid", rsp_valid, 1'b1);
        reset = 1'b1;
        #1;
        check("rst.rdy0", req0_ready, 1'b0);
        tick();
        check_rsp("rst_full", 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);

        // First tie after reset goes to req0.
        reset = 1'b0; rsp_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'h3C; req1_f = F_AND;
        #1;
        check("tie.rdy0", req0_ready, 1'b1);
        check("tie.rdy1", req1_ready, 1'b0);
        tick();
        check_rsp("tie", 1'b1, 1'b0, 8'h02, 1'b0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
